i2c_codec_responder: RTL and testbench
======================================

Name: i2c_codec_responder

Overview:
- Synthesizable I2C slave that models the write-only control port of the audio codec (WM8731-style, 7-bit device address, 16-bit write frames).
- Answers the existing I2C configuration master and captures each configuration word into an internal register file.
- Sits on the AC_SCL/AC_SDA pair in loopback/simulation builds so codec configuration can be checked without silicon.
- Runs on main_clk (50 MHz); SCL ≤ 400 kHz, so at least 16 clk cycles per SCL phase.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit slave address acknowledged (write byte 0x34).
- NUM_REGS, 11, number of implemented registers (addresses 0..NUM_REGS-1). Register 15 is always the reset register.

Ports:
- clk  input  1  system clock (main_clk).
- reset  input  1  asynchronous, active-high reset.
- scl_in  input  1  I2C clock as seen on the bus.
- sda_in  input  1  I2C data as seen on the bus.
- sda_oe  output  1  1 = pull SDA low; 0 = release SDA.
- wr_valid  output  1  one-cycle pulse when a register write is committed.
- wr_addr  output  7  register address of the last committed frame.
- wr_data  output  9  data of the last committed frame.
- rd_addr  input  4  register-file read address.
- rd_data  output  9  registered read data.
- busy  output  1  high from START until STOP.
- err_count  output  8  saturating protocol-error counter.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is asynchronous and active-high.
  - Reset values: sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, rd_data=0, busy=0, err_count=0, all registers=0, state=IDLE.
- Input sampling:
  - scl_in and sda_in each pass through a 2-FF synchronizer, then a third flop for edge detection.
  - All decisions use the synchronized values.
- Bus conditions:
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - Data bit: sampled on the scl rising edge, MSB first.
  - sda_oe changes only on a detected scl falling edge.
- States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP.
- Bit counter: 3 bits, cleared on START and on entry to each byte state.
- START, from any state (including a repeated START): go to ADDR, busy=1. A partially received frame is discarded.
- ADDR: after 8 bits, compare the upper 7 bits with DEV_ADDR.
  - Match and R/W=0: go to ACK_A.
  - Match and R/W=1: reads are unsupported. NACK, err_count+1, go to WAIT_STOP.
  - Mismatch: NACK silently, no count, go to WAIT_STOP.
- ACK states:
  - Assert sda_oe on the scl falling edge after the 8th bit.
  - Release on the next scl falling edge.
  - Then advance: ACK_A→BYTE1, ACK_1→BYTE2, ACK_2→WAIT_STOP.
- BYTE1 and BYTE2:
  - BYTE1[7:1] is the register address; BYTE1[0] is data bit 8.
  - BYTE2 is data[7:0].
  - Commit occurs on the scl falling edge that asserts the ACK_2 acknowledge. That cycle: wr_valid=1, wr_addr and wr_data updated.
- Register file effect of a commit:
  - addr < NUM_REGS: write the register.
  - addr = 15: clear all registers to 0, any data.
  - Any other address: ACK anyway, no write, err_count+1.
  - wr_valid pulses in all three cases.
- WAIT_STOP: SDA stays released; any further bytes are NACKed. STOP → IDLE, busy=0.
- STOP outside IDLE/WAIT_STOP (truncated frame): no commit, err_count+1, go to IDLE. STOP in IDLE has no effect.
- err_count saturates at 255.
- Read port: rd_data <= reg[rd_addr] each clk (1-cycle latency). Returns 0 for rd_addr ≥ NUM_REGS and for 15.
- Simultaneous commit and read of the same address: rd_data returns the old value this cycle, the new value next cycle.
- Reset asserted mid-transaction: sda_oe drops to 0 immediately (asynchronously). The transaction is lost; the responder waits for a new START.

Test Plan:
- Write bytes 0x34,0x08,0x12 then STOP at 100 kHz → three ACKs (SDA low on the 9th clock of each byte); one wr_valid with wr_addr=4, wr_data=0x012; rd_addr=4 gives rd_data=0x012 after 1 clk; busy falls after STOP.
- Address byte 0x36 followed by two bytes → no ACK on any byte, no wr_valid, err_count stays 0, register contents unchanged.
- Read-address byte 0x35 → NACK, err_count=1, SDA released until STOP.
- 0x34,0x0E then STOP (truncated frame) → no wr_valid, err_count=1; then 0x34,0x1E,0x00 (reset register) → wr_valid with wr_addr=0x0F; registers 0..10 all read 0.
- Repeated START after 0x34,0x08, then 0x34,0x0A,0xFF → only one commit: wr_addr=5, wr_data=0x0FF.
- Assert reset while sda_oe=1 during ACK_1 → sda_oe=0 within the same cycle, busy=0, err_count=0; the next complete frame is accepted normally.

Source files
------------

// File: rtl/i2c_codec_responder_if.sv
// Bus bundle for the codec control-port responder: I2C lines, commit strobe,
// register-file read port and status.
`timescale 1ns/1ps
interface i2c_codec_responder_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic [3:0] rd_addr;
  logic [8:0] rd_data;
  logic       busy;
  logic [7:0] err_count;

  modport slave (
    input  scl_in, sda_in, rd_addr,
    output sda_oe, wr_valid, wr_addr, wr_data, rd_data, busy, err_count
  );

  modport master (
    output scl_in, sda_in, rd_addr,
    input  sda_oe, wr_valid, wr_addr, wr_data, rd_data, busy, err_count
  );
endinterface

// File: rtl/i2c_codec_responder.sv
// Write-only I2C slave modelling a WM8731-style codec control port: 7-bit address,
// 16-bit frames {reg[6:0], data[8:0]} captured into a small register file.
`timescale 1ns/1ps
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         NUM_REGS = 11
) (
  input logic                  clk,
  input logic                  reset,
  i2c_codec_responder_if.slave bus
);

  localparam int DATA_W = 9;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ACK_A     = 3'd2;
  localparam logic [2:0] S_BYTE1     = 3'd3;
  localparam logic [2:0] S_ACK_1     = 3'd4;
  localparam logic [2:0] S_BYTE2     = 3'd5;
  localparam logic [2:0] S_ACK_2     = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  localparam logic [6:0] RESET_REG = 7'd15;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2: previous sample for edge detection.
  // Idle bus level is high, so reset to 1 to avoid phantom edges.
  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= bus.scl_in;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= bus.sda_in;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  logic scl_rise, scl_fall, scl_high, start_cond, stop_cond;

  assign scl_rise   = scl_p1 & ~scl_p2;
  assign scl_fall   = ~scl_p1 & scl_p2;
  assign scl_high   = scl_p1 & scl_p2;
  assign start_cond = scl_high & sda_p2 & ~sda_p1;
  assign stop_cond  = scl_high & ~sda_p2 & sda_p1;

  logic [2:0]        state;
  logic [2:0]        bit_cnt;
  logic [6:0]        shreg;
  logic [6:0]        addr_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        byte_nxt;
  logic              byte_done;
  logic              commit;
  logic              addr_in_range;
  logic              addr_bad;

  assign byte_nxt      = {shreg, sda_p1};
  assign byte_done     = scl_rise & (bit_cnt == 3'd7);
  // sda_oe doubles as the ACK phase flag: low = about to acknowledge, high = about to release.
  assign commit        = (state == S_ACK_2) & scl_fall & ~bus.sda_oe;
  assign addr_in_range = int'(addr_q) < NUM_REGS;
  assign addr_bad      = ~addr_in_range & (addr_q != RESET_REG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      bit_cnt       <= 3'd0;
      shreg         <= 7'd0;
      addr_q        <= 7'd0;
      data_q        <= '0;
      bus.sda_oe    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.err_count <= 8'd0;
      bus.wr_valid  <= 1'b0;
      bus.wr_addr   <= 7'd0;
      bus.wr_data   <= '0;
    end else begin
      bus.wr_valid <= 1'b0;
      if (start_cond) begin
        state      <= S_ADDR;
        bus.busy   <= 1'b1;
        bit_cnt    <= 3'd0;
        bus.sda_oe <= 1'b0;
      end else if (stop_cond) begin
        if (state != S_IDLE && state != S_WAIT_STOP)
          bus.err_count <= sat_inc(bus.err_count);
        state      <= S_IDLE;
        bus.busy   <= 1'b0;
        bus.sda_oe <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_BYTE1, S_BYTE2: begin
            if (scl_rise) begin
              shreg   <= byte_nxt[6:0];
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
              case (state)
                S_ADDR: begin
                  if (byte_nxt[7:1] == DEV_ADDR && !byte_nxt[0]) begin
                    state <= S_ACK_A;
                  end else begin
                    // Reads are a protocol error; foreign addresses are simply ignored.
                    if (byte_nxt[7:1] == DEV_ADDR)
                      bus.err_count <= sat_inc(bus.err_count);
                    state <= S_WAIT_STOP;
                  end
                end
                S_BYTE1: begin
                  addr_q    <= byte_nxt[7:1];
                  data_q[8] <= byte_nxt[0];
                  state     <= S_ACK_1;
                end
                default: begin
                  data_q[7:0] <= byte_nxt;
                  state       <= S_ACK_2;
                end
              endcase
            end
          end
          S_ACK_A, S_ACK_1, S_ACK_2: begin
            if (scl_fall) begin
              if (!bus.sda_oe) begin
                bus.sda_oe <= 1'b1;
                if (commit) begin
                  bus.wr_valid <= 1'b1;
                  bus.wr_addr  <= addr_q;
                  bus.wr_data  <= data_q;
                  if (addr_bad)
                    bus.err_count <= sat_inc(bus.err_count);
                end
              end else begin
                bus.sda_oe <= 1'b0;
                bit_cnt    <= 3'd0;
                case (state)
                  S_ACK_A: state <= S_BYTE1;
                  S_ACK_1: state <= S_BYTE2;
                  default: state <= S_WAIT_STOP;
                endcase
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(bus.rd_addr) == i) rd_mux = regs[i];
  end

  // Read data is registered from the pre-commit contents, so a same-cycle
  // write shows up on rd_data one clock later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bus.rd_data <= '0;
    end else begin
      bus.rd_data <= rd_mux;
      if (commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr_q == RESET_REG)
            regs[i] <= '0;
          else if (int'(addr_q) == i)
            regs[i] <= data_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: table of write frames plus hand-written
// truncated, reset-register, repeated-START and mid-ACK reset sequences.
`timescale 1ns/1ps
module tb_i2c_codec_responder;

  localparam int Q_SLOW = 2500;  // quarter SCL period at 100 kHz
  localparam int Q_FAST = 625;   // quarter SCL period at 400 kHz

  logic clk;
  logic reset;
  logic m_sda;
  int   q;

  i2c_codec_responder_if bus ();

  i2c_codec_responder #(.DEV_ADDR(7'h1A), .NUM_REGS(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Open-drain bus: the line is low if either side pulls it.
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int         wr_cnt = 0;
  logic [6:0] last_addr = '0;
  logic [8:0] last_data = '0;
  logic [8:0] rd_at_commit = '0;
  logic [8:0] rd_after = '0;
  logic       grab_next = 1'b0;

  always @(negedge clk) begin
    if (grab_next) begin
      rd_after  <= bus.rd_data;
      grab_next <= 1'b0;
    end
    if (bus.wr_valid) begin
      wr_cnt       <= wr_cnt + 1;
      last_addr    <= bus.wr_addr;
      last_data    <= bus.wr_data;
      rd_at_commit <= bus.rd_data;
      grab_next    <= 1'b1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b, output logic line);
    #(q); m_sda = b;
    #(q); bus.scl_in = 1'b1;
    #(q); line = bus.sda_in;
    #(q); bus.scl_in = 1'b0;
  endtask

  task automatic do_start();
    #(q); m_sda = 1'b1;
    #(q); bus.scl_in = 1'b1;
    #(q); m_sda = 1'b0;
    #(q); bus.scl_in = 1'b0;
  endtask

  task automatic do_stop();
    #(q); m_sda = 1'b0;
    #(q); bus.scl_in = 1'b1;
    #(q); m_sda = 1'b1;
    #(q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic line;
    for (int i = 7; i >= 0; i--) send_bit(b[i], line);
    send_bit(1'b1, line);
    acked = ~line;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [8:0] d);
    @(negedge clk);
    bus.rd_addr = a;
    @(posedge clk);
    #1 d = bus.rd_data;
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    bit         slow;
    logic [2:0] ack;
    bit         wr;
    logic [6:0] addr;
    logic [8:0] data;
    int         err_inc;
  } frame_t;

  typedef struct {
    logic [3:0] a;
    logic [8:0] d;
  } rb_t;

  frame_t frames [6];
  rb_t    rbs [6];

  initial begin
    logic       a0, a1, a2, line;
    logic [8:0] d;
    int         exp_err;
    int         wr0;

    frames[0] = '{8'h34, 8'h08, 8'h12, 1'b1, 3'b111, 1'b1, 7'h04, 9'h012, 0};
    frames[1] = '{8'h36, 8'h08, 8'h12, 1'b0, 3'b000, 1'b0, 7'h00, 9'h000, 0};
    frames[2] = '{8'h34, 8'h15, 8'hA5, 1'b0, 3'b111, 1'b1, 7'h0A, 9'h1A5, 0};
    frames[3] = '{8'h34, 8'h16, 8'h33, 1'b0, 3'b111, 1'b1, 7'h0B, 9'h033, 1};
    frames[4] = '{8'h34, 8'h01, 8'h80, 1'b0, 3'b111, 1'b1, 7'h00, 9'h180, 0};
    frames[5] = '{8'h35, 8'h08, 8'h12, 1'b0, 3'b000, 1'b0, 7'h00, 9'h000, 1};

    rbs[0] = '{4'd4,  9'h012};
    rbs[1] = '{4'd10, 9'h1A5};
    rbs[2] = '{4'd0,  9'h180};
    rbs[3] = '{4'd11, 9'h000};
    rbs[4] = '{4'd15, 9'h000};
    rbs[5] = '{4'd5,  9'h000};

    reset       = 1'b1;
    bus.scl_in  = 1'b1;
    m_sda       = 1'b1;
    bus.rd_addr = 4'd0;
    q           = Q_FAST;
    exp_err     = 0;
    repeat (5) @(posedge clk);
    #1;
    check("reset sda_oe",    {31'd0, bus.sda_oe},    0);
    check("reset wr_valid",  {31'd0, bus.wr_valid},  0);
    check("reset wr_addr",   {25'd0, bus.wr_addr},   0);
    check("reset wr_data",   {23'd0, bus.wr_data},   0);
    check("reset rd_data",   {23'd0, bus.rd_data},   0);
    check("reset busy",      {31'd0, bus.busy},      0);
    check("reset err_count", {24'd0, bus.err_count}, 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    for (int f = 0; f < 6; f++) begin
      q   = frames[f].slow ? Q_SLOW : Q_FAST;
      wr0 = wr_cnt;
      do_start();
      check($sformatf("frame%0d busy after START", f), {31'd0, bus.busy}, 1);
      send_byte(frames[f].b0, a0);
      send_byte(frames[f].b1, a1);
      send_byte(frames[f].b2, a2);
      do_stop();
      repeat (6) @(posedge clk);
      #1;
      exp_err += frames[f].err_inc;
      check($sformatf("frame%0d ack0", f), {31'd0, a0}, {31'd0, frames[f].ack[2]});
      check($sformatf("frame%0d ack1", f), {31'd0, a1}, {31'd0, frames[f].ack[1]});
      check($sformatf("frame%0d ack2", f), {31'd0, a2}, {31'd0, frames[f].ack[0]});
      check($sformatf("frame%0d wr_valid pulses", f), wr_cnt - wr0, {31'd0, frames[f].wr});
      if (frames[f].wr) begin
        check($sformatf("frame%0d wr_addr", f), {25'd0, last_addr}, {25'd0, frames[f].addr});
        check($sformatf("frame%0d wr_data", f), {23'd0, last_data}, {23'd0, frames[f].data});
      end
      check($sformatf("frame%0d err_count", f), {24'd0, bus.err_count}, exp_err);
      check($sformatf("frame%0d busy after STOP", f), {31'd0, bus.busy}, 0);
    end

    for (int r = 0; r < 6; r++) begin
      read_reg(rbs[r].a, d);
      check($sformatf("readback reg%0d", rbs[r].a), {23'd0, d}, {23'd0, rbs[r].d});
    end

    // Truncated frame: STOP while the data byte is still expected.
    q   = Q_FAST;
    wr0 = wr_cnt;
    do_start();
    send_byte(8'h34, a0);
    send_byte(8'h0E, a1);
    do_stop();
    repeat (6) @(posedge clk);
    #1;
    exp_err++;
    check("truncated wr_valid pulses", wr_cnt - wr0, 0);
    check("truncated err_count", {24'd0, bus.err_count}, exp_err);
    read_reg(4'd7, d);
    check("truncated reg7 untouched", {23'd0, d}, 0);

    // Reset register clears the whole file.
    wr0 = wr_cnt;
    do_start();
    send_byte(8'h34, a0);
    send_byte(8'h1E, a1);
    send_byte(8'h00, a2);
    do_stop();
    repeat (6) @(posedge clk);
    #1;
    check("resetreg acks", {29'd0, a0, a1, a2}, 7);
    check("resetreg wr_valid pulses", wr_cnt - wr0, 1);
    check("resetreg wr_addr", {25'd0, last_addr}, 32'h0F);
    check("resetreg err_count", {24'd0, bus.err_count}, exp_err);
    for (int r = 0; r < 11; r++) begin
      read_reg(r[3:0], d);
      check($sformatf("resetreg reg%0d cleared", r), {23'd0, d}, 0);
    end

    // Repeated START abandons the first frame; watch reg5 across the commit.
    @(negedge clk) bus.rd_addr = 4'd5;
    wr0 = wr_cnt;
    do_start();
    send_byte(8'h34, a0);
    send_byte(8'h08, a1);
    do_start();
    send_byte(8'h34, a0);
    send_byte(8'h0A, a1);
    send_byte(8'hFF, a2);
    do_stop();
    repeat (6) @(posedge clk);
    #1;
    check("rstart wr_valid pulses", wr_cnt - wr0, 1);
    check("rstart wr_addr", {25'd0, last_addr}, 5);
    check("rstart wr_data", {23'd0, last_data}, 32'h0FF);
    check("rstart rd_data at commit (old)", {23'd0, rd_at_commit}, 0);
    check("rstart rd_data after commit (new)", {23'd0, rd_after}, 32'h0FF);
    check("rstart err_count", {24'd0, bus.err_count}, exp_err);
    read_reg(4'd4, d);
    check("rstart reg4 not written", {23'd0, d}, 0);

    // Reset while acknowledging the register-address byte.
    do_start();
    send_byte(8'h34, a0);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h08 >> i), line);
    #(q);
    check("ack1 sda_oe asserted", {31'd0, bus.sda_oe}, 1);
    reset = 1'b1;
    #1;
    check("midreset sda_oe", {31'd0, bus.sda_oe}, 0);
    check("midreset busy", {31'd0, bus.busy}, 0);
    check("midreset err_count", {24'd0, bus.err_count}, 0);
    #100 reset = 1'b0;
    do_stop();
    repeat (6) @(posedge clk);
    #1;
    check("post-reset stray STOP err_count", {24'd0, bus.err_count}, 0);
    read_reg(4'd5, d);
    check("post-reset reg5 cleared", {23'd0, d}, 0);

    wr0 = wr_cnt;
    do_start();
    send_byte(8'h34, a0);
    send_byte(8'h0C, a1);
    send_byte(8'h55, a2);
    do_stop();
    repeat (6) @(posedge clk);
    #1;
    check("post-reset acks", {29'd0, a0, a1, a2}, 7);
    check("post-reset wr_valid pulses", wr_cnt - wr0, 1);
    check("post-reset wr_addr", {25'd0, last_addr}, 6);
    check("post-reset wr_data", {23'd0, last_data}, 32'h055);
    check("post-reset err_count", {24'd0, bus.err_count}, 0);
    read_reg(4'd6, d);
    check("post-reset reg6", {23'd0, d}, 32'h055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
